double_to_sig16b_conv: RTL and testbench



---
 rtl/double_to_sig16b_conv.sv | 73 +++++++
 tb/tb_double_to_sig16b_conv.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/double_to_sig16b_conv.sv
// IEEE-754 binary64 sample to signed 16-bit PCM, staged on enable and published on a counter match.
// Optional macro D2S16_ROUND_EN: round half away from zero (default build truncates toward zero).
module double_to_sig16b_conv #(
  parameter logic [12:0] LOAD_COUNT = 13'd0
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic [12:0] sampling_cycle_counter,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b
);

  logic        sign_bit;
  logic [10:0] exp_field;
  logic [51:0] frac_field;
  logic [52:0] mant;
  logic [5:0]  shamt;
  logic [15:0] mag;
  logic [15:0] conv_next;
  logic [15:0] conv_q;

  assign sign_bit   = double[63];
  assign exp_field  = double[62:52];
  assign frac_field = double[51:0];
  assign mant       = {1'b1, frac_field};

  // Only meaningful for 1007 <= e <= 1022, where the shift lies in 38..53.
  assign shamt = 6'(11'd1060 - exp_field);

`ifdef D2S16_ROUND_EN
  logic [16:0] mag_half;

  // Keep one extra bit below the LSB, add it in, then drop it.
  assign mag_half = 17'(mant >> (shamt - 6'd1));
  assign mag      = 16'((mag_half + 17'd1) >> 1);
`else
  assign mag = 16'(mant >> shamt);
`endif

  always_comb begin
    conv_next = 16'h0000;
    if (exp_field == 11'd2047 && frac_field != 52'd0) begin
      conv_next = 16'h0000;
    end else if (exp_field >= 11'd1023) begin
      conv_next = sign_bit ? 16'h8000 : 16'h7FFF;
    end else if (exp_field < 11'd1007) begin
      conv_next = 16'h0000;
    end else if (sign_bit) begin
      // mag never exceeds 32768 here, which negates to 16'h8000 exactly.
      conv_next = 16'(-mag);
    end else if (mag > 16'd32767) begin
      conv_next = 16'h7FFF;
    end else begin
      conv_next = mag;
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      conv_q <= 16'h0000;
      sig16b <= 16'h0000;
    end else begin
      if (enable) begin
        conv_q <= conv_next;
      end
      if (sampling_cycle_counter == LOAD_COUNT) begin
        sig16b <= conv_q;
      end
    end
  end

endmodule

// File: tb/tb_double_to_sig16b_conv.sv
// Scoreboard bench for double_to_sig16b_conv: real-arithmetic reference model, monitor checks
// every published word and that sig16b holds between counter matches.
module tb_double_to_sig16b_conv;

  localparam logic [12:0] LOAD = 13'd3;

  logic        clk_operation = 1'b0;
  logic        rst;
  logic [12:0] sampling_cycle_counter;
  logic        enable;
  logic [63:0] dbl;
  logic [15:0] sig16b;

  always #5 clk_operation = ~clk_operation;

  double_to_sig16b_conv #(.LOAD_COUNT(LOAD)) dut (
    .clk_operation         (clk_operation),
    .rst                   (rst),
    .sampling_cycle_counter(sampling_cycle_counter),
    .enable                (enable),
    .double                (dbl),
    .sig16b                (sig16b)
  );

  logic [15:0] exp_q[$];
  logic [15:0] model_conv;
  int          tests = 0;
  int          fails = 0;
  logic        have_last = 1'b0;
  logic [15:0] last_exp = 16'h0000;
  int          n_out = 0;

  function automatic logic [15:0] ref_conv(input logic [63:0] d);
    real v, a, m;
    v = $bitstoreal(d);
    if (v != v) return 16'h0000;
    a = (v < 0.0) ? -v : v;
    a = a * 32768.0;
`ifdef D2S16_ROUND_EN
    m = $floor(a + 0.5);
`else
    m = $floor(a);
`endif
    if (d[63]) begin
      if (m >= 32768.0) return 16'h8000;
      return 16'(-$rtoi(m));
    end
    if (m >= 32767.0) return 16'h7FFF;
    return 16'($rtoi(m));
  endfunction

  function automatic logic [63:0] rand_double();
    logic [63:0] d;
    int sel;
    sel = $urandom_range(0, 9);
    d   = {$urandom, $urandom};
    if (sel == 1) begin
      case ($urandom_range(0, 5))
        0: d[62:52] = 11'd0;
        1: d[62:52] = 11'd2047;
        2: d[62:52] = 11'd1022;
        3: d[62:52] = 11'd1023;
        4: d[62:52] = 11'd1006;
        default: d[62:52] = 11'd1007;
      endcase
    end else if (sel != 0) begin
      d[62:52] = 11'($urandom_range(1000, 1024));
    end
    return d;
  endfunction

  // One clock: drive at negedge, model the edge, advance the counter.
  task automatic step(input logic r, input logic en, input logic [63:0] d, output logic matched);
    rst    = r;
    enable = en;
    dbl    = d;
    @(posedge clk_operation);
    matched = (sampling_cycle_counter == LOAD);
    if (r) begin
      model_conv = 16'h0000;
      exp_q.push_back(16'h0000);
    end else begin
      if (matched) exp_q.push_back(model_conv);
      if (en) model_conv = ref_conv(d);
    end
    @(negedge clk_operation);
    sampling_cycle_counter = (sampling_cycle_counter == 13'd15) ? 13'd0 : sampling_cycle_counter + 13'd1;
  endtask

  // Stage one value, then idle (with a changing double) until the next match publishes it.
  task automatic convert(input logic [63:0] d);
    logic m;
    step(1'b0, 1'b1, d, m);
    do step(1'b0, 1'b0, {$urandom, $urandom}, m); while (!m);
  endtask

  // Enable on the very edge where the counter matches.
  task automatic convert_at_match(input logic [63:0] d);
    logic m;
    while (sampling_cycle_counter != LOAD) step(1'b0, 1'b0, {$urandom, $urandom}, m);
    step(1'b0, 1'b1, d, m);
    do step(1'b0, 1'b0, {$urandom, $urandom}, m); while (!m);
  endtask

  initial begin
    forever begin
      @(negedge clk_operation);
      if (exp_q.size() > 0) begin
        last_exp  = exp_q.pop_front();
        have_last = 1'b1;
        n_out++;
        tests++;
        if (sig16b !== last_exp) begin
          fails++;
          $display("[TB] FAIL out%0d: sig16b=%h expected %h", n_out, sig16b, last_exp);
        end else begin
          $display("[TB] out%0d sig16b=%h ok", n_out, sig16b);
        end
      end else if (have_last) begin
        tests++;
        if (sig16b !== last_exp) begin
          fails++;
          $display("[TB] FAIL hold: sig16b=%h expected %h at %0t", sig16b, last_exp, $time);
        end
      end
    end
  end

  initial begin
    logic m;
    logic [63:0] dirs[14];
    rst                    = 1'b1;
    enable                 = 1'b1;
    dbl                    = 64'h3FE0000000000000;
    sampling_cycle_counter = 13'd0;
    model_conv             = 16'h0000;

    step(1'b1, 1'b1, 64'h3FE0000000000000, m);
    step(1'b1, 1'b1, 64'h3FE0000000000000, m);

    dirs = '{64'h3FE0000000000000, 64'hBFD0000000000000, 64'h3FF0000000000000,
             64'hBFF0000000000000, 64'h4008000000000000, 64'hFFF0000000000000,
             64'h7FF8000000000000, 64'h3EF8000000000000, 64'h3EF0000000000000,
             64'h3F08000000000000, 64'h8000000000000000, 64'h3FEFFFFFFFFFFFFF,
             64'hBFEFFFFFFFFFFFFF, 64'h7FF0000000000000};
    foreach (dirs[i]) convert(dirs[i]);

    convert_at_match(64'h3FD0000000000000);
    convert_at_match(64'hBFE8000000000000);

    for (int i = 0; i < 3000; i++) begin
      if (i > 100 && $urandom_range(0, 299) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), rand_double(), m);
      else
        step(1'b0, ($urandom_range(0, 3) == 0), rand_double(), m);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, rand_double(), m);

    @(negedge clk_operation);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d words left in scoreboard, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
